// File: rtl/apb_imem_loader_if.sv
// APB3 bus bundle between the SoC interconnect and the instruction-memory loader.
interface apb_imem_loader_if #(
  parameter int DATA_LENGTH = 32
) ();
  logic                   psel;
  logic                   penable;
  logic                   pwrite;
  logic [31:0]            paddr;
  logic [DATA_LENGTH-1:0] pwdata;
  logic [DATA_LENGTH-1:0] prdata;
  logic                   pready;
  logic                   pslverr;

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_imem_loader.sv
// APB3 slave that loads and reads back instruction-memory words and owns the
// core_select handoff bit; drives the wrapper's APB-side memory port.
module apb_imem_loader #(
  parameter int          DATA_LENGTH    = 32,
  parameter int          ADDRESS_LENGTH = 11,
  parameter logic [31:0] CTRL_ADDR      = 32'h0000_2000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  apb_imem_loader_if.slave       apb,
  output logic                   mem_en,
  output logic                   mem_wr_en,
  output logic                   mem_rd_en,
  output logic [31:0]            mem_address,
  output logic [DATA_LENGTH-1:0] mem_data_in,
  output logic [1:0]             mem_data_length,
  input  logic [DATA_LENGTH-1:0] mem_data_out,
  output logic                   core_select
);

  localparam logic [31:0] MEM_LIMIT = 32'(1) << (ADDRESS_LENGTH + 2);

  typedef enum logic [2:0] {IDLE, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   mem_en_q, mem_en_d;
  logic                   mem_wr_en_q, mem_wr_en_d;
  logic                   mem_rd_en_q, mem_rd_en_d;
  logic [31:0]            mem_address_q, mem_address_d;
  logic [DATA_LENGTH-1:0] mem_data_in_q, mem_data_in_d;
  logic [1:0]             mem_len_q, mem_len_d;
  logic [DATA_LENGTH-1:0] prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;
  logic                   core_select_q, core_select_d;
  logic                   ctrl_wr_q, ctrl_wr_d;
  logic                   ctrl_bit_q, ctrl_bit_d;

  logic        setup;
  logic        mem_hit;
  logic        ctrl_hit;
  logic        mem_ok;
  logic [31:0] word_idx;

  assign setup    = apb.psel && !apb.penable;
  assign mem_hit  = (apb.paddr < MEM_LIMIT) && (apb.paddr[1:0] == 2'b00);
  assign ctrl_hit = (apb.paddr == CTRL_ADDR);
  // Memory accesses are refused once the core owns the RAM.
  assign mem_ok   = mem_hit && !core_select_q;
  assign word_idx = 32'(apb.paddr[ADDRESS_LENGTH+1:2]);

  always_comb begin
    state_d       = state_q;
    mem_en_d      = 1'b0;
    mem_wr_en_d   = 1'b0;
    mem_rd_en_d   = 1'b0;
    mem_address_d = '0;
    mem_data_in_d = '0;
    mem_len_d     = 2'b00;
    prdata_d      = '0;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    core_select_d = core_select_q;
    ctrl_wr_d     = 1'b0;
    ctrl_bit_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup) begin
          if (mem_ok) begin
            mem_en_d      = 1'b1;
            mem_address_d = word_idx;
            if (apb.pwrite) begin
              state_d       = WR_ISSUE;
              mem_wr_en_d   = 1'b1;
              mem_len_d     = 2'b11;
              mem_data_in_d = apb.pwdata;
            end else begin
              state_d     = RD_ISSUE;
              mem_rd_en_d = 1'b1;
            end
          end else begin
            state_d  = RESP;
            pready_d = 1'b1;
            if (ctrl_hit) begin
              ctrl_wr_d  = apb.pwrite;
              ctrl_bit_d = apb.pwdata[0];
              if (!apb.pwrite)
                prdata_d = {{(DATA_LENGTH-1){1'b0}}, core_select_q};
            end else begin
              pslverr_d = 1'b1;
            end
          end
        end
      end
      WR_ISSUE: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
        end
      end
      RD_ISSUE: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          // Strobes stay up so the wrapper presents the freshly read word.
          state_d       = RD_CAPTURE;
          mem_en_d      = 1'b1;
          mem_rd_en_d   = 1'b1;
          mem_address_d = mem_address_q;
        end
      end
      RD_CAPTURE: begin
        if (!apb.psel) begin
          state_d = IDLE;
        end else begin
          state_d  = RESP;
          pready_d = 1'b1;
          prdata_d = mem_data_out;
        end
      end
      RESP: begin
        state_d = IDLE;
        if (ctrl_wr_q)
          core_select_d = ctrl_bit_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mem_en_q      <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_address_q <= '0;
      mem_data_in_q <= '0;
      mem_len_q     <= 2'b00;
      prdata_q      <= '0;
      pready_q      <= 1'b0;
      pslverr_q     <= 1'b0;
      core_select_q <= 1'b0;
      ctrl_wr_q     <= 1'b0;
      ctrl_bit_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_en_q      <= mem_en_d;
      mem_wr_en_q   <= mem_wr_en_d;
      mem_rd_en_q   <= mem_rd_en_d;
      mem_address_q <= mem_address_d;
      mem_data_in_q <= mem_data_in_d;
      mem_len_q     <= mem_len_d;
      prdata_q      <= prdata_d;
      pready_q      <= pready_d;
      pslverr_q     <= pslverr_d;
      core_select_q <= core_select_d;
      ctrl_wr_q     <= ctrl_wr_d;
      ctrl_bit_q    <= ctrl_bit_d;
    end
  end

  assign mem_en          = mem_en_q;
  assign mem_wr_en       = mem_wr_en_q;
  assign mem_rd_en       = mem_rd_en_q;
  assign mem_address     = mem_address_q;
  assign mem_data_in     = mem_data_in_q;
  assign mem_data_length = mem_len_q;
  assign core_select     = core_select_q;
  assign apb.prdata      = prdata_q;
  assign apb.pready      = pready_q;
  assign apb.pslverr     = pslverr_q;

endmodule

// File: tb/tb_apb_imem_loader.sv
// Randomized APB bench for apb_imem_loader with a behavioural RAM on the memory
// port and an address-map reference model of memory contents and core_select.
module tb_apb_imem_loader;

  logic        clk;
  logic        rst_n;
  logic        mem_en, mem_wr_en, mem_rd_en, core_select;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0]  mem_data_length;

  apb_imem_loader_if #(.DATA_LENGTH(32)) bus ();

  apb_imem_loader #(
    .DATA_LENGTH(32), .ADDRESS_LENGTH(11), .CTRL_ADDR(32'h0000_2000)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .apb             (bus),
    .mem_en          (mem_en),
    .mem_wr_en       (mem_wr_en),
    .mem_rd_en       (mem_rd_en),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_length (mem_data_length),
    .mem_data_out    (mem_data_out),
    .core_select     (core_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM standing in for the instruction memory wrapper.
  bit [31:0] ram [0:2047];
  bit [31:0] ram_q;
  always @(posedge clk) begin
    if (mem_en && mem_wr_en) ram[mem_address[10:0]] <= mem_data_in;
    if (mem_en && mem_rd_en) ram_q <= ram[mem_address[10:0]];
  end
  assign mem_data_out = ram_q;

  // Reference model: expected memory image and ownership bit.
  bit [31:0] ref_mem [0:2047];
  bit        ref_core;

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (!mem_wr_en && mem_data_length != 2'b00) viol++;
      if ((mem_wr_en || mem_rd_en) && !mem_en) viol++;
      if (mem_wr_en && mem_rd_en) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      bus.psel = 1'b0; bus.penable = 1'b0;
    end
  endtask

  task automatic apb_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat,
                          output int en_cnt, output logic [31:0] a1_addr,
                          output logic [31:0] a1_din, output logic [1:0] a1_len,
                          output logic sel_at_setup);
    @(posedge clk); #1;
    sel_at_setup = core_select;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr;
    bus.paddr = addr; bus.pwdata = wdata;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    lat = 1; en_cnt = 0;
    a1_addr = mem_address; a1_din = mem_data_in; a1_len = mem_data_length;
    if (mem_en) en_cnt++;
    while (!bus.pready && lat < 10) begin
      @(posedge clk); #1;
      lat++;
      if (mem_en) en_cnt++;
    end
    rdata = bus.prdata;
    err   = bus.pslverr;
  endtask

  task automatic run(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd, a1a, a1d;
    logic [1:0]  a1l;
    logic        er, sel;
    int          lat, enc, idx;
    bit          is_ctrl, is_mem, is_err;
    is_ctrl = (addr == 32'h2000);
    is_mem  = (addr < 32'h2000) && (addr % 4 == 0) && !ref_core;
    is_err  = !is_ctrl && !is_mem;
    idx     = int'(addr[12:2]);
    apb_xfer(wr, addr, wdata, rd, er, lat, enc, a1a, a1d, a1l, sel);
    chk("core_sel", 32'(sel), 32'(ref_core));
    chk("latency", 32'(lat), is_mem ? (wr ? 32'd2 : 32'd3) : 32'd1);
    chk("pslverr", 32'(er), 32'(is_err));
    chk("mem_cycles", 32'(enc), is_mem ? (wr ? 32'd1 : 32'd2) : 32'd0);
    if (!wr)
      chk("prdata", rd, is_err ? 32'd0 : (is_ctrl ? 32'(ref_core) : ref_mem[idx]));
    if (is_mem)
      chk("mem_address", a1a, 32'(idx));
    if (is_mem && wr) begin
      chk("mem_data_in", a1d, wdata);
      chk("mem_len", 32'(a1l), 32'd3);
      ref_mem[idx] = wdata;
    end
    if (is_ctrl && wr) ref_core = wdata[0];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int          cnt, kind;
    bit          w;
    logic [31:0] a, wd;

    rst_n = 1'b0;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0;
    ref_core = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", 32'(bus.pready), 32'd0);
    chk("rst_pslverr", 32'(bus.pslverr), 32'd0);
    chk("rst_prdata", bus.prdata, 32'd0);
    chk("rst_strobes", {29'd0, mem_en, mem_wr_en, mem_rd_en}, 32'd0);
    chk("rst_addr", mem_address, 32'd0);
    chk("rst_core_sel", 32'(core_select), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(3);
    chk("idle_outs", {26'd0, bus.pready, bus.pslverr, mem_en, mem_data_length, core_select}, 32'd0);

    // Directed load, read-back and boundary addresses.
    run(1'b1, 32'h10, 32'hDEAD_BEEF);
    run(1'b0, 32'h10, 32'h0);
    run(1'b1, 32'h1FFC, 32'h1234_5678);
    run(1'b0, 32'h1FFC, 32'h0);
    run(1'b0, 32'h0, 32'h0);

    // Aborted write: issued strobe commits, no response follows.
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h20; bus.pwdata = 32'hA5A5_1234;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    chk("abort_wr_en", 32'(mem_wr_en), 32'd1);
    bus.psel = 1'b0; bus.penable = 1'b0;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus.pready || mem_en) cnt++;
    end
    chk("abort_quiet", 32'(cnt), 32'd0);
    ref_mem[8] = 32'hA5A5_1234;
    run(1'b0, 32'h20, 32'h0);

    // Ownership handoff and error decode.
    run(1'b1, 32'h2000, 32'h1);
    idle(1);
    chk("handoff", 32'(core_select), 32'd1);
    run(1'b0, 32'h0, 32'h0);
    run(1'b1, 32'h10, 32'h5555_AAAA);
    run(1'b0, 32'h2000, 32'h0);
    run(1'b1, 32'h2000, 32'h0);
    run(1'b0, 32'h3000, 32'h0);
    run(1'b1, 32'h13, 32'hFFFF_FFFF);
    run(1'b0, 32'h2004, 32'h0);
    idle(1);

    // Async reset in the capture cycle of a read.
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h10;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    chk("cap_rd_en", 32'(mem_rd_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_strobes", {30'd0, mem_en, mem_rd_en}, 32'd0);
    chk("arst_pready", 32'(bus.pready), 32'd0);
    chk("arst_core_sel", 32'(core_select), 32'd0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    ref_core = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    run(1'b0, 32'h10, 32'h0);

    // Randomized mix of memory, control and erroneous accesses.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 9));
      w    = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (kind <= 5)      a = 32'($urandom_range(0, 31)) << 2;
      else if (kind == 6) begin
        a  = 32'h2000;
        wd = ($urandom_range(0, 3) == 0) ? 32'h1 : 32'h0;
      end
      else if (kind == 7) a = $urandom;
      else if (kind == 8) a = (32'($urandom_range(0, 2047)) << 2) | 32'($urandom_range(1, 3));
      else                a = 32'($urandom_range(2040, 2047)) << 2;
      run(w, a, wd);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(2);

    chk("strobe_rules", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_imem_loader.md
Name: apb_imem_loader

Overview:
- APB3 slave bridge that drives the APB-side port of the instruction memory wrapper.
- Lets the host or boot master load program words into instruction memory and read them back.
- Owns the core_select control bit, which hands the memory over to the RISC-V core once loading is done.
- Sits between the SoC APB interconnect and the wrapper's from_apb_mem_* / to_apb_mem_data_out ports.

Parameters:
- DATA_LENGTH, 32, APB data width and memory word width.
- ADDRESS_LENGTH, 11, memory word-index width (2048 words, 8 KB byte span).
- CTRL_ADDR, 32'h0000_2000, byte address of the control register.

Ports:
- clk  in  1  single system clock (also PCLK).
- rst_n  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB enable (access phase).
- pwrite  in  1  APB write = 1, read = 0.
- paddr  in  32  APB byte address.
- pwdata  in  DATA_LENGTH  APB write data.
- prdata  out  DATA_LENGTH  APB read data, registered.
- pready  out  1  APB ready, registered.
- pslverr  out  1  APB error, valid only when pready = 1.
- mem_en  out  1  to from_apb_mem_en.
- mem_wr_en  out  1  to from_apb_mem_wr_en.
- mem_rd_en  out  1  to from_apb_mem_rd_en.
- mem_address  out  32  to from_apb_mem_address; word index, zero-extended.
- mem_data_in  out  DATA_LENGTH  to from_apb_mem_data_in.
- mem_data_length  out  2  to from_apb_mem_data_length (APB encoding: 11 = word, 00 = none).
- mem_data_out  in  DATA_LENGTH  from to_apb_mem_data_out.
- core_select  out  1  0 = APB owns memory, 1 = core owns memory.

Behaviour:
- Reset (async, rst_n low): every output goes to 0, including core_select, prdata, pready and pslverr. FSM goes to IDLE. Reset mid-transfer abandons the transfer and issues no further memory cycle.
- Address decode, performed in IDLE on setup phase (psel=1, penable=0):
  - MEM: paddr < 2^(ADDRESS_LENGTH+2) and paddr[1:0] == 0.
  - CTRL: paddr == CTRL_ADDR.
  - Anything else is ERR.
  - MEM while core_select = 1 is also ERR; no memory cycle is issued.
- The decode result, word index paddr[ADDRESS_LENGTH+1:2] and pwdata are registered at the setup edge.
- FSM states: IDLE, WR_ISSUE, RD_ISSUE, RD_CAPTURE, RESP.
  - IDLE → WR_ISSUE on MEM write; → RD_ISSUE on MEM read; → RESP on CTRL or ERR.
  - WR_ISSUE: mem_en=1, mem_wr_en=1, mem_data_length=2'b11, mem_address and mem_data_in driven. The RAM writes at the end of this cycle. Next state RESP.
  - RD_ISSUE: mem_en=1, mem_rd_en=1, mem_address driven. The RAM samples the address at the end of this cycle. Next state RD_CAPTURE.
  - RD_CAPTURE: mem_en=1 and mem_rd_en=1 are held so the wrapper passes fresh data. prdata <= mem_data_out at the end of the cycle. Next state RESP.
  - RESP: pready=1 for exactly one cycle, pslverr=1 if ERR. Next state IDLE.
- Latency, counted as access-phase cycles including the pready cycle: read = 3, write = 2, CTRL/ERR = 1.
- Memory strobes are 0 in IDLE and RESP. mem_data_length = 2'b00 whenever mem_wr_en = 0.
- CTRL register:
  - Write: core_select <= pwdata[0] during RESP.
  - Read: prdata = {31'b0, core_select}.
- ERR responses: prdata = 0 and no state change.
- psel deasserted before RESP: return to IDLE at the next edge, with no pready pulse and no further strobes. A write already issued in WR_ISSUE stays committed.
- Back-to-back transfers: a new setup phase is accepted in IDLE on the cycle immediately after RESP.

Test Plan:
- Reset then idle: rst_n low → all outputs 0, core_select=0. Release with psel=0 → outputs stay 0.
- Word write: paddr=0x10, pwdata=0xDEADBEEF, core_select=0 → WR_ISSUE cycle shows mem_address=4, mem_wr_en=1, mem_data_length=11. pready rises 2 cycles into access, pslverr=0.
- Read back: paddr=0x10 read → mem_address=4 for 2 cycles with mem_rd_en=1. prdata=0xDEADBEEF with pready on access cycle 3.
- Control handoff: write 1 to 0x2000 → core_select=1 after pready. A following read of 0x0 → pslverr=1, prdata=0, mem_en never asserted. Read of 0x2000 → prdata=1.
- Errors: access to 0x3000, or to 0x13 (misaligned) → 1-cycle pready with pslverr=1, no memory strobes.
- Async reset mid-read: assert rst_n low during RD_CAPTURE → mem_en, mem_rd_en and pready drop immediately, core_select=0. Next read transfer completes normally.
